// File: rtl/button_conditioner_pkg.sv
// Shared types and helpers for the button conditioner.
// Repeat FSM encoding and elaboration-time arithmetic.
package button_conditioner_pkg;

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_e;

  function automatic int max_int(
    input int a,
    input int b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_conditioner_channel.sv
// One button lane: synchroniser, debounce filter,
// press/release strobes and optional auto-repeat.
module button_channel
  import button_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_RATE     = 10000000,
  parameter bit REPEAT_EN       = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_repeat
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TMR_W =
    $clog2(max_int(REPEAT_DELAY, REPEAT_RATE) + 1);

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TMR_W-1:0] DLY_LAST =
    TMR_W'(REPEAT_DELAY - 1);
  localparam logic [TMR_W-1:0] RATE_LAST =
    TMR_W'(REPEAT_RATE - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             level_q;
  logic             flip;
  logic             rise;
  logic             fall;

  rpt_state_e       state_q;
  rpt_state_e       state_d;
  logic [TMR_W-1:0] tmr_q;
  logic [TMR_W-1:0] tmr_d;
  logic             rpt_d;

  logic press_q;
  logic release_q;
  logic rpt_q;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in};
    end
  end

  // Level flips only on the D-th consecutive disagreeing sample.
  assign flip = (s != level_q) && (cnt_q == CNT_LAST);
  assign rise = flip && s;
  assign fall = flip && !s;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if ((s == level_q) || flip) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (flip) begin
        level_q <= s;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    rpt_d   = 1'b0;
    unique case (state_q)
      RPT_IDLE: begin
        if (rise) begin
          state_d = RPT_DELAY;
          tmr_d   = '0;
        end
      end
      RPT_DELAY: begin
        if (tmr_q == DLY_LAST) begin
          rpt_d   = 1'b1;
          state_d = RPT_REPEAT;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      RPT_REPEAT: begin
        if (tmr_q == RATE_LAST) begin
          rpt_d = 1'b1;
          tmr_d = '0;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      default: begin
        state_d = RPT_IDLE;
        tmr_d   = '0;
      end
    endcase
    // Release wins over a coincident repeat tick.
    if (fall || !REPEAT_EN) begin
      state_d = RPT_IDLE;
      tmr_d   = '0;
      rpt_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RPT_IDLE;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      rpt_q     <= 1'b0;
    end else begin
      press_q   <= rise;
      release_q <= fall;
      rpt_q     <= rpt_d;
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign btn_repeat  = rpt_q;

endmodule

// File: rtl/button_conditioner.sv
// Button bank front end: one independent
// conditioning lane per raw button input.
module button_conditioner #(
  parameter int                CHANNELS        = 5,
  parameter int                SYNC_STAGES     = 2,
  parameter int                DEBOUNCE_CYCLES = 1000000,
  parameter logic [CHANNELS-1:0] REPEAT_MASK   = '0,
  parameter int                REPEAT_DELAY    = 50000000,
  parameter int                REPEAT_RATE     = 10000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] btn_in,
  output logic [CHANNELS-1:0] btn_level,
  output logic [CHANNELS-1:0] btn_press,
  output logic [CHANNELS-1:0] btn_release,
  output logic [CHANNELS-1:0] btn_repeat
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    button_channel #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_RATE     (REPEAT_RATE),
      .REPEAT_EN       (REPEAT_MASK[i])
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .btn_in      (btn_in[i]),
      .btn_level   (btn_level[i]),
      .btn_press   (btn_press[i]),
      .btn_release (btn_release[i]),
      .btn_repeat  (btn_repeat[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus
// random bouncing, all checked against a window-based model.
module tb_button_conditioner;

  localparam int CH = 2;
  localparam int SS = 2;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RR = 3;
  localparam logic [CH-1:0] RM = 2'b01;

  logic          clk = 1'b0;
  logic          rst;
  logic [CH-1:0] btn_in;
  logic [CH-1:0] btn_level;
  logic [CH-1:0] btn_press;
  logic [CH-1:0] btn_release;
  logic [CH-1:0] btn_repeat;

  always #5 clk = ~clk;

  button_conditioner #(
    .CHANNELS        (CH),
    .SYNC_STAGES     (SS),
    .DEBOUNCE_CYCLES (DB),
    .REPEAT_MASK     (RM),
    .REPEAT_DELAY    (RD),
    .REPEAT_RATE     (RR)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_in      (btn_in),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .btn_repeat  (btn_repeat)
  );

  int errs   = 0;
  int checks = 0;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  // Model: samples since reset; level flips when the last DB
  // synchronised samples all disagree with it.
  logic [CH-1:0] hist[$];
  logic [CH-1:0] m_level;
  logic [CH-1:0] m_press;
  logic [CH-1:0] m_rel;
  logic [CH-1:0] m_rpt;
  int            press_n[CH];

  function automatic logic s_at(input int t, input int c);
    if (t - SS < 1) return 1'b0;
    return hist[t-SS-1][c];
  endfunction

  task automatic model_clear();
    hist.delete();
    m_level = '0;
    m_press = '0;
    m_rel   = '0;
    m_rpt   = '0;
    for (int c = 0; c < CH; c++) press_n[c] = 0;
  endtask

  task automatic model_edge();
    int n;
    int age;
    logic stable;
    hist.push_back(btn_in);
    n = hist.size();
    for (int c = 0; c < CH; c++) begin
      stable = 1'b1;
      for (int k = 0; k < DB; k++) begin
        if (s_at(n - k, c) == m_level[c]) stable = 1'b0;
      end
      m_press[c] = stable && !m_level[c];
      m_rel[c]   = stable && m_level[c];
      if (stable) m_level[c] = !m_level[c];
      if (m_press[c]) press_n[c] = n;
      age = n - press_n[c];
      m_rpt[c] = RM[c] && m_level[c] && !m_press[c] &&
                 (age >= RD) && (((age - RD) % RR) == 0);
    end
  endtask

  // Event statistics relative to the last stimulus change.
  int rel;
  int press_at[CH];
  int rel_at[CH];
  int n_press[CH];
  int n_rel[CH];
  int n_rpt[CH];
  int rpt_q[$];

  task automatic clear_stats();
    rel = 0;
    rpt_q.delete();
    for (int c = 0; c < CH; c++) begin
      press_at[c] = 0;
      rel_at[c]   = 0;
      n_press[c]  = 0;
      n_rel[c]    = 0;
      n_rpt[c]    = 0;
    end
  endtask

  task automatic step(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      model_edge();
      #1;
      chk("level", 32'(btn_level), 32'(m_level));
      chk("press", 32'(btn_press), 32'(m_press));
      chk("release", 32'(btn_release), 32'(m_rel));
      chk("repeat", 32'(btn_repeat), 32'(m_rpt));
      rel++;
      for (int c = 0; c < CH; c++) begin
        if (btn_press[c]) begin
          n_press[c]++;
          press_at[c] = rel;
        end
        if (btn_release[c]) begin
          n_rel[c]++;
          rel_at[c] = rel;
        end
        if (btn_repeat[c]) n_rpt[c]++;
      end
      if (btn_repeat[0]) rpt_q.push_back(rel);
    end
  endtask

  task automatic outs_zero(input string tag);
    chk({tag, "_level"}, 32'(btn_level), 32'd0);
    chk({tag, "_press"}, 32'(btn_press), 32'd0);
    chk({tag, "_release"}, 32'(btn_release), 32'd0);
    chk({tag, "_repeat"}, 32'(btn_repeat), 32'd0);
  endtask

  // Asserts rst between edges so the clear is seen asynchronously.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    outs_zero("rst_async");
    repeat (2) @(posedge clk);
    #1;
    outs_zero("rst_hold");
    model_clear();
    rst = 1'b0;
    clear_stats();
  endtask

  int hold_left[CH];

  initial begin
    rst    = 1'b1;
    btn_in = 2'b11;
    model_clear();
    clear_stats();

    // Buttons held through reset come out as fresh presses.
    do_reset();
    step(8);
    chk("t1_press_at0", press_at[0], 6);
    chk("t1_press_at1", press_at[1], 6);
    chk("t1_npress0", n_press[0], 1);
    chk("t1_npress1", n_press[1], 1);
    btn_in = 2'b00;
    step(12);

    // Clean step in both directions.
    clear_stats();
    btn_in = 2'b01;
    step(9);
    chk("t2_press_at", press_at[0], 6);
    chk("t2_npress", n_press[0], 1);
    clear_stats();
    btn_in = 2'b00;
    step(9);
    chk("t2_rel_at", rel_at[0], 6);
    chk("t2_nrel", n_rel[0], 1);

    // Glitch one cycle shy of the debounce window.
    clear_stats();
    btn_in = 2'b01;
    step(3);
    btn_in = 2'b00;
    step(10);
    chk("t3_npress", n_press[0], 0);
    chk("t3_nrel", n_rel[0], 0);

    // Bounce, then settle high; release lands on a repeat tick.
    clear_stats();
    for (int k = 0; k < 3; k++) begin
      btn_in = 2'b01;
      step(2);
      btn_in = 2'b00;
      step(2);
    end
    btn_in = 2'b01;
    rel = 0;
    step(10);
    chk("t4_npress", n_press[0], 1);
    chk("t4_press_at", press_at[0], 6);
    btn_in = 2'b00;
    step(10);
    chk("t4_nrel", n_rel[0], 1);
    chk("t4_nrpt", n_rpt[0], 0);

    // Auto-repeat cadence on the masked channel.
    clear_stats();
    btn_in = 2'b01;
    step(26);
    chk("t5_press_at", press_at[0], 6);
    chk("t5_rpt_cnt", rpt_q.size(), 4);
    if (rpt_q.size() >= 3) begin
      chk("t5_rpt1", rpt_q[0], 16);
      chk("t5_rpt2", rpt_q[1], 19);
      chk("t5_rpt3", rpt_q[2], 22);
    end
    clear_stats();
    btn_in = 2'b00;
    step(6);
    chk("t5_rel_at", rel_at[0], 6);
    clear_stats();
    step(12);
    chk("t5_rpt_after", n_rpt[0], 0);
    clear_stats();
    btn_in = 2'b10;
    step(36);
    chk("t5_npress1", n_press[1], 1);
    chk("t5_nrpt1", n_rpt[1], 0);
    btn_in = 2'b00;
    step(10);

    // Reset while repeating restarts the whole sequence.
    clear_stats();
    btn_in = 2'b01;
    step(20);
    do_reset();
    step(20);
    chk("t6_press_at", press_at[0], 6);
    chk("t6_npress", n_press[0], 1);
    if (rpt_q.size() >= 1) begin
      chk("t6_rpt1", rpt_q[0], 16);
    end else begin
      chk("t6_rpt_cnt", rpt_q.size(), 1);
    end
    btn_in = 2'b00;
    step(10);

    // Random bouncing with mixed hold lengths on both channels.
    for (int c = 0; c < CH; c++) hold_left[c] = 1;
    for (int cyc = 0; cyc < 1200; cyc++) begin
      for (int c = 0; c < CH; c++) begin
        hold_left[c]--;
        if (hold_left[c] == 0) begin
          btn_in[c] = ~btn_in[c];
          if ($urandom_range(0, 2) == 0)
            hold_left[c] = $urandom_range(10, 40);
          else
            hold_left[c] = $urandom_range(1, 5);
        end
      end
      if (cyc == 600) do_reset();
      step(1);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
